register_file_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_fwd_mux.sv | 41 ++++
 rtl/register_file_mp.sv | 104 ++++++++++
 tb/tb_register_file_mp.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } regfile_state_t;

endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port: selects stored data or same-cycle write data, then applies
// the register-0 and not-yet-initialised overrides.
module regfile_fwd_mux #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                        run,
    input  logic [AW-1:0]               rd_number,
    input  logic [XLEN-1:0]             stored_value,
    input  logic                        stored_busy,
    input  logic [NWRITE-1:0]           write_enable,
    input  logic [NWRITE-1:0][AW-1:0]   write_number,
    input  logic [NWRITE-1:0][XLEN-1:0] write_value,
    output logic [XLEN-1:0]             value,
    output logic                        busy
);

    logic [XLEN-1:0] fwd_value;

    // Ascending scan so the highest-index matching write port is the last to assign.
    always_comb begin
        fwd_value = stored_value;
        for (int w = 0; w < NWRITE; w++) begin
            if (write_enable[w] && (write_number[w] == rd_number)) begin
                fwd_value = write_value[w];
            end
        end
    end

    always_comb begin
        value = '0;
        busy  = 1'b0;
        if (run && !((ZERO_REG != 0) && (rd_number == '0))) begin
            value = fwd_value;
            busy  = stored_busy;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with per-register busy scoreboard and a
// one-entry-per-cycle clearing sweep after every reset.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREAD-1:0][AW-1:0]    in_reg_number,
    output logic [NREAD-1:0][XLEN-1:0]  out_reg_value,
    output logic [NREAD-1:0]            out_reg_busy,
    input  logic [NWRITE-1:0]           in_write_enable,
    input  logic [NWRITE-1:0][AW-1:0]   in_write_number,
    input  logic [NWRITE-1:0][XLEN-1:0] in_write_value,
    input  logic                        in_reserve_enable,
    input  logic [AW-1:0]               in_reserve_number,
    output logic                        out_ready
);

    regfile_state_t  state;
    logic [AW-1:0]   sweep_cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic [NREGS-1:0] busy;
    logic            run;

    assign run = (state == RUN);

    function automatic logic writable(input logic [AW-1:0] n);
        return !((ZERO_REG != 0) && (n == '0));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
            out_ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == AW'(NREGS - 1)) begin
                        state     <= RUN;
                        out_ready <= 1'b1;
                    end
                end
                RUN: begin
                    state     <= RUN;
                    out_ready <= 1'b1;
                end
                default: begin
                    state     <= INIT;
                    sweep_cnt <= '0;
                    out_ready <= 1'b0;
                end
            endcase
        end
    end

    // Later write ports overwrite earlier ones; the reserve comes last so it beats a write.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                mem[sweep_cnt]  <= '0;
                busy[sweep_cnt] <= 1'b0;
            end else begin
                for (int w = 0; w < NWRITE; w++) begin
                    if (in_write_enable[w] && writable(in_write_number[w])) begin
                        mem[in_write_number[w]]  <= in_write_value[w];
                        busy[in_write_number[w]] <= 1'b0;
                    end
                end
                if (in_reserve_enable && writable(in_reserve_number)) begin
                    busy[in_reserve_number] <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        regfile_fwd_mux #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NWRITE   (NWRITE),
            .ZERO_REG (ZERO_REG)
        ) u_fwd_mux (
            .run          (run),
            .rd_number    (in_reg_number[i]),
            .stored_value (mem[in_reg_number[i]]),
            .stored_busy  (busy[in_reg_number[i]]),
            .write_enable (in_write_enable),
            .write_number (in_write_number),
            .write_value  (in_write_value),
            .value        (out_reg_value[i]),
            .busy         (out_reg_busy[i])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: init sweep, write priority, forwarding,
// scoreboard, register 0 and reset during the sweep.
module tb_register_file_mp;

    logic             clk;
    logic             rst_n;
    logic [1:0][4:0]  in_reg_number;
    logic [1:0][31:0] out_reg_value;
    logic [1:0]       out_reg_busy;
    logic [1:0]       in_write_enable;
    logic [1:0][4:0]  in_write_number;
    logic [1:0][31:0] in_write_value;
    logic             in_reserve_enable;
    logic [4:0]       in_reserve_number;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    register_file_mp dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_reg_number     (in_reg_number),
        .out_reg_value     (out_reg_value),
        .out_reg_busy      (out_reg_busy),
        .in_write_enable   (in_write_enable),
        .in_write_number   (in_write_number),
        .in_write_value    (in_write_value),
        .in_reserve_enable (in_reserve_enable),
        .in_reserve_number (in_reserve_number),
        .out_ready         (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_write_enable   = '0;
        in_write_number   = '0;
        in_write_value    = '0;
        in_reserve_enable = 1'b0;
        in_reserve_number = '0;
    endtask

    task automatic test_reset();
        int ready_at;
        idle_inputs();
        in_reg_number = '0;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (out_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b expected 0", out_ready);
        end
        rst_n = 1'b1;
        ready_at = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (out_ready === 1'b1) begin
                ready_at = c;
                break;
            end
        end
        checks++;
        if (ready_at !== 32) begin
            errors++;
            $display("[TB] FAIL init_latency got %0d expected 32", ready_at);
        end
        for (int r = 0; r < 32; r++) begin
            in_reg_number[0] = 5'(r);
            in_reg_number[1] = 5'(31 - r);
            #1;
            checks++;
            if (out_reg_value !== '0 || out_reg_busy !== 2'b00) begin
                errors++;
                $display("[TB] FAIL init_clear r%0d got value %h busy %b expected 0 busy 00",
                         r, out_reg_value, out_reg_busy);
            end
        end
    endtask

    task automatic test_write_priority();
        idle_inputs();
        in_write_enable = 2'b11;
        in_write_number[0] = 5'd5;  in_write_value[0] = 32'h11;
        in_write_number[1] = 5'd5;  in_write_value[1] = 32'h22;
        in_reg_number[0] = 5'd5;
        in_reg_number[1] = 5'd6;
        #1;
        checks++;
        if (out_reg_value[0] !== 32'h22) begin
            errors++;
            $display("[TB] FAIL prio_same_cycle got %h expected 00000022", out_reg_value[0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_reg_value[0] !== 32'h22) begin
            errors++;
            $display("[TB] FAIL prio_stored got %h expected 00000022", out_reg_value[0]);
        end
        in_write_enable = 2'b11;
        in_write_number[0] = 5'd3;  in_write_value[0] = 32'h0000_AAAA;
        in_write_number[1] = 5'd4;  in_write_value[1] = 32'h0000_BBBB;
        in_reg_number[0] = 5'd4;
        in_reg_number[1] = 5'd3;
        #1;
        checks++;
        if (out_reg_value[0] !== 32'h0000_BBBB || out_reg_value[1] !== 32'h0000_AAAA) begin
            errors++;
            $display("[TB] FAIL fwd_two_ports got %h %h expected 0000bbbb 0000aaaa",
                     out_reg_value[0], out_reg_value[1]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_reg_value[0] !== 32'h0000_BBBB || out_reg_value[1] !== 32'h0000_AAAA) begin
            errors++;
            $display("[TB] FAIL store_two_ports got %h %h expected 0000bbbb 0000aaaa",
                     out_reg_value[0], out_reg_value[1]);
        end
        in_write_enable = 2'b01;
        in_write_number[0] = 5'd5;  in_write_value[0] = 32'h1234_5678;
        in_reg_number[1] = 5'd5;
        #1;
        checks++;
        if (out_reg_value[1] !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL fwd_port0_only got %h expected 12345678", out_reg_value[1]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        in_reserve_enable = 1'b1;
        in_reserve_number = 5'd7;
        in_reg_number[0] = 5'd7;
        #1;
        checks++;
        if (out_reg_busy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_not_forwarded got %b expected 0", out_reg_busy[0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_reg_busy[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_after_reserve got %b expected 1", out_reg_busy[0]);
        end
        in_write_enable = 2'b10;
        in_write_number[1] = 5'd7;
        in_write_value[1]  = 32'h0000_DEAD;
        #1;
        checks++;
        if (out_reg_busy[0] !== 1'b1 || out_reg_value[0] !== 32'h0000_DEAD) begin
            errors++;
            $display("[TB] FAIL write_same_cycle got busy %b value %h expected 1 0000dead",
                     out_reg_busy[0], out_reg_value[0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_reg_busy[0] !== 1'b0 || out_reg_value[0] !== 32'h0000_DEAD) begin
            errors++;
            $display("[TB] FAIL busy_cleared got busy %b value %h expected 0 0000dead",
                     out_reg_busy[0], out_reg_value[0]);
        end
    endtask

    task automatic test_collision();
        idle_inputs();
        in_reserve_enable = 1'b1;
        in_reserve_number = 5'd9;
        in_write_enable = 2'b01;
        in_write_number[0] = 5'd9;
        in_write_value[0]  = 32'h5;
        in_reg_number[1] = 5'd9;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_reg_busy[1] !== 1'b1 || out_reg_value[1] !== 32'h5) begin
            errors++;
            $display("[TB] FAIL reserve_vs_write got busy %b value %h expected 1 00000005",
                     out_reg_busy[1], out_reg_value[1]);
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        in_write_enable = 2'b11;
        in_write_number[0] = 5'd0;  in_write_value[0] = 32'hFFFF_FFFF;
        in_write_number[1] = 5'd0;  in_write_value[1] = 32'hFFFF_FFFF;
        in_reserve_enable = 1'b1;
        in_reserve_number = 5'd0;
        in_reg_number = '0;
        #1;
        checks++;
        if (out_reg_value !== '0 || out_reg_busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL zero_same_cycle got %h busy %b expected 0 busy 00",
                     out_reg_value, out_reg_busy);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_reg_value !== '0 || out_reg_busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL zero_later got %h busy %b expected 0 busy 00",
                     out_reg_value, out_reg_busy);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int ready_at;
        idle_inputs();
        for (int r = 0; r < 32; r += 2) begin
            in_write_enable = 2'b11;
            in_write_number[0] = 5'(r);      in_write_value[0] = 32'hA500_0000 + r;
            in_write_number[1] = 5'(r + 1);  in_write_value[1] = 32'hA500_0000 + r + 1;
            tick();
        end
        idle_inputs();
        in_reserve_enable = 1'b1;
        in_reserve_number = 5'd12;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_reg_number[0] = 5'd12;
        in_reg_number[1] = 5'd1;
        ready_at = -1;
        for (int c = 1; c <= 100; c++) begin
            if (c == 20) begin
                in_write_enable = 2'b01;
                in_write_number[0] = 5'd12;
                in_write_value[0]  = 32'h77;
                in_reserve_enable  = 1'b1;
                in_reserve_number  = 5'd13;
                #1;
                checks++;
                if (out_reg_value !== '0 || out_reg_busy !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL init_outputs got %h busy %b expected 0 busy 00",
                             out_reg_value, out_reg_busy);
                end
            end
            tick();
            idle_inputs();
            if (out_ready === 1'b1) begin
                ready_at = c;
                break;
            end
        end
        checks++;
        if (ready_at !== 32) begin
            errors++;
            $display("[TB] FAIL resweep_latency got %0d expected 32", ready_at);
        end
        for (int r = 0; r < 32; r++) begin
            in_reg_number[0] = 5'(r);
            in_reg_number[1] = 5'(r);
            #1;
            checks++;
            if (out_reg_value !== '0 || out_reg_busy !== 2'b00) begin
                errors++;
                $display("[TB] FAIL resweep_clear r%0d got value %h busy %b expected 0 busy 00",
                         r, out_reg_value, out_reg_busy);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        in_reg_number = '0;
        test_reset();
        test_write_priority();
        test_scoreboard();
        test_collision();
        test_zero_reg();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
